ccff_chain_loader: RTL
======================

# ccff_chain_loader

Configuration-chain loader feeding the `ccff_head` input of the first routing/connection-block memory in a column, such as the `mux_tree_tapbuf_size*_mem` chain of a `cby` tile. It accepts configuration words from the bitstream controller over a valid/ready handshake. It serializes exactly `CHAIN_LEN` bits onto `ccff_head`, MSB first, while holding `config_enable` high for exactly one `prog_clk` cycle per bit. An optional tail check monitors `ccff_tail` to confirm that the chain shifted out its reset contents.

## Interface
Parameters:
- `CHAIN_LEN`, default 40: number of configuration flops in the downstream chain; must be ≥ 1.
- `DATA_W`, default 8: configuration word width; must be ≥ 1.

Ports:
- `prog_clk` in 1: sole clock.
- `pReset` in 1: synchronous, active-high reset.
- `start` in 1: begins a load; sampled only in IDLE.
- `cfg_data` in `DATA_W`: configuration word, MSB shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts a word this cycle.
- `ccff_head` out 1: serial bit to the chain head.
- `config_enable` out 1: chain shift enable.
- `ccff_tail` in 1: tail of the chain; used only with the tail-check option.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the load completes.
- `tail_err` out 1: tail-check result.

## Operation
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE:
  - `start`=1 moves to WAIT_WORD.
  - Clears the bit counter (`$clog2(CHAIN_LEN+1)` bits) and the tail-check flag.
- WAIT_WORD:
  - `cfg_ready`=1.
  - On `cfg_valid & cfg_ready`, load `cfg_data` into the shift register and move to SHIFT.
  - Set the word-bit count to min(`DATA_W`, `CHAIN_LEN` − bits already shifted).
- SHIFT:
  - `config_enable`=1 and `ccff_head`=shift-register MSB.
  - Each cycle: shift left by one, increment the bit counter, decrement the word-bit count.
  - When the word-bit count reaches 0: go to DONE if the bit counter equals `CHAIN_LEN`, otherwise go to WAIT_WORD.
- Partial last word: only its upper (`CHAIN_LEN` mod `DATA_W`) bits are shifted; the remaining low bits are discarded.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored. `cfg_valid` outside WAIT_WORD is ignored and the word is not consumed.
- `ccff_head` and `config_enable` come directly from flops and are glitch-free.
- `ccff_head` holds the last shifted value while `config_enable`=0.
- `pReset` mid-load:
  - Next cycle the state is IDLE and all outputs are 0.
  - The chain holds partial data and the controller must reload it.
- `pReset` takes priority over every other input.

## Timing
- Reset values: `cfg_ready`=0, `ccff_head`=0, `config_enable`=0, `busy`=0, `done`=0, `tail_err`=0.
- `start` sampled at edge 0 puts the block in WAIT_WORD during cycle 1.
- A handshake at the end of cycle n gives SHIFT in cycles n+1 .. n+k, where k is that word's bit count.
- Each word costs at least k+1 cycles; there are no back-to-back words.
- With `cfg_valid` held high, `CHAIN_LEN`=40 and `DATA_W`=8:
  - word j shifts in cycles 2+9j .. 9+9j;
  - `done`=1 in cycle 46; IDLE in cycle 47.
- The chain captures `ccff_head` at each `prog_clk` edge where `config_enable`=1.
- The first bit shifted ends in the last flop of the chain.

## Configuration
- Macro `CCFF_TAIL_CHECK_EN`, when defined:
  - On every cycle with `config_enable`=1, sample `ccff_tail` (the bit being shifted out).
  - Any 1 sampled sets a sticky flag.
  - `tail_err` takes the flag value in the DONE cycle and holds it until the next accepted `start` or `pReset`.
  - A post-reset chain (all 0) gives `tail_err`=0.
- Macro undefined:
  - `ccff_tail` is ignored and `tail_err` is tied to 0.
  - No flag logic is synthesized.

## Test plan
- Reset: assert `pReset` for 2 cycles with random inputs → all outputs 0. After release, `start`=0 keeps IDLE indefinitely.
- Full load (40/8), words 0xA5, 0x3C, 0xFF, 0x00, 0x81, `cfg_valid` held high:
  - `config_enable` high for exactly 40 cycles; `done` in cycle 46.
  - The behavioural chain model reads bits 1010_0101_0011_1100_1111_1111_0000_0000_1000_0001, first bit at the far end.
- Back-pressure: drop `cfg_valid` for 3 cycles before word 2 → `config_enable`=0 and `ccff_head` stable during the gap. Final chain contents are identical to the full-load test and `done` is 3 cycles later.
- Partial word (`CHAIN_LEN`=12): words 0xC3, 0x9F → 12 shifts with bit order 1100_0011_1001. Word 2 uses 4 shift cycles; `done` follows the last shift.
- Reset mid-shift: `pReset` on the 5th shift of word 1 → `busy`=0 and `config_enable`=0 next cycle. A following `start` plus the full-load stimulus yields the correct chain contents.
- `CCFF_TAIL_CHECK_EN`:
  - Chain model preloaded with one 1 → `tail_err`=1 at `done`.
  - Second load from a clean chain → `tail_err`=0 after `start`.
  - Macro undefined → `tail_err`=0 throughout.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// Configuration word handshake between the bitstream controller (master)
// and the chain loader (slave).
// Handshake: a word transfers on every prog_clk edge where cfg_valid and
// cfg_ready are both high; cfg_data must be stable while cfg_valid is high,
// and cfg_ready never depends combinationally on cfg_valid.
interface ccff_chain_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes CHAIN_LEN bits, MSB of each word
// first, onto ccff_head with one config_enable pulse per bit.
// Optional tail check enabled by defining the macro CCFF_TAIL_CHECK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int DATA_W    = 8
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  ccff_chain_loader_if.slave   cfg,
  output logic                 ccff_head,
  output logic                 config_enable,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done,
  output logic                 tail_err,
  output logic [1:0]           fsm_state
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     bit_cnt;
  logic [WW-1:0]     wcnt;
  logic [WW-1:0]     word_bits;
  logic              head_q;
  logic              ce_q;
  logic              handshake;
  logic              last_bit;
  int                rem;

  assign cfg.cfg_ready = (state == S_WAIT);
  assign handshake     = cfg.cfg_valid & cfg.cfg_ready;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign ccff_head     = head_q;
  assign config_enable = ce_q;
  assign fsm_state     = state;
  assign last_bit      = (wcnt == WW'(1));

  // Bits this word contributes: a full word, or only what the chain still needs.
  always_comb begin
    rem       = CHAIN_LEN - int'(bit_cnt);
    word_bits = WW'(DATA_W);
    if (rem < DATA_W) word_bits = WW'(rem);
  end

  // Main FSM with shift register, counters and registered chain outputs.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state   <= S_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      wcnt    <= '0;
      head_q  <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (start) state <= S_WAIT;
        end
        S_WAIT: begin
          if (handshake) begin
            // First bit goes straight to the head flop; the rest wait in sreg.
            head_q <= cfg.cfg_data[DATA_W-1];
            sreg   <= cfg.cfg_data << 1;
            wcnt   <= word_bits;
            ce_q   <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + CW'(1);
          wcnt    <= wcnt - WW'(1);
          if (last_bit) begin
            // Head keeps the last bit; leftover low bits of a partial word drop.
            ce_q  <= 1'b0;
            state <= (bit_cnt == CW'(CHAIN_LEN - 1)) ? S_DONE : S_WAIT;
          end else begin
            head_q <= sreg[DATA_W-1];
            sreg   <= sreg << 1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  logic flag;
  logic err_q;

  // Sticky record of any 1 leaving the chain tail during this load.
  always_ff @(posedge prog_clk) begin
    if (pReset || state == S_IDLE) flag <= 1'b0;
    else if (ce_q && ccff_tail)    flag <= 1'b1;
  end

  // Holds the result from DONE until the next accepted start.
  always_ff @(posedge prog_clk) begin
    if (pReset)                          err_q <= 1'b0;
    else if (state == S_IDLE && start)   err_q <= 1'b0;
    else if (state == S_DONE)            err_q <= flag;
  end

  assign tail_err = (state == S_DONE) ? flag : err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign tail_err    = 1'b0;
`endif

endmodule
